// File: rtl/midi_pkg.sv
// Shared MIDI constants, parser state type and message-length helper.
package midi_pkg;

    localparam logic [3:0] ST_NOTE_OFF = 4'h8;
    localparam logic [3:0] ST_NOTE_ON  = 4'h9;
    localparam logic [3:0] ST_CC       = 4'hB;
    localparam logic [7:0] SYS_SYSEX   = 8'hF0;
    localparam logic [7:0] SYS_RT_MIN  = 8'hF8;

    localparam logic [6:0] CC_ALL_SOUND_OFF = 7'd120;
    localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

    typedef enum logic [1:0] {
        S_IDLE,
        S_D1,
        S_D2,
        S_SYSEX
    } parse_state_e;

    function automatic logic [1:0] msg_len(input logic [3:0] typ);
        return (typ == 4'hC || typ == 4'hD) ? 2'd1 : 2'd2;
    endfunction

endpackage

// File: rtl/midi_note_tracker.sv
// MIDI byte-stream parser keeping a monophonic last-note-priority
// note state for the LCD controller and tone generator.
module midi_note_tracker
    import midi_pkg::*;
#(
    parameter logic [3:0] CHANNEL = 4'd0,
    parameter logic       OMNI    = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_res_n,
    input  logic       i_rx_valid,
    input  logic [7:0] i_rx_data,
    output logic       o_note_en,
    output logic [6:0] o_note_num,
    output logic [6:0] o_velocity,
    output logic       o_note_on_stb,
    output logic       o_note_off_stb
);

    parse_state_e state;
    logic [3:0]   rs_type;
    logic [3:0]   rs_chan;
    logic [6:0]   d1;

    logic       is_rt;
    logic       is_chst;
    logic       is_sysex;
    logic       is_syscom;
    logic       is_data;
    logic       accept;
    logic [6:0] d2;
    logic       msg_on;
    logic       msg_off;
    logic       msg_cc_off;

    assign is_rt     = i_rx_data >= SYS_RT_MIN;
    assign is_chst   = i_rx_data[7] && (i_rx_data < SYS_SYSEX);
    assign is_sysex  = i_rx_data == SYS_SYSEX;
    assign is_syscom = i_rx_data[7] && !is_rt && !is_chst && !is_sysex;
    assign is_data   = !i_rx_data[7];
    assign d2        = i_rx_data[6:0];

    assign accept     = OMNI || (rs_chan == CHANNEL);
    assign msg_on     = (rs_type == ST_NOTE_ON) && (d2 != 7'd0);
    assign msg_off    = (rs_type == ST_NOTE_OFF) ||
                        ((rs_type == ST_NOTE_ON) && (d2 == 7'd0));
    assign msg_cc_off = (rs_type == ST_CC) &&
                        ((d1 == CC_ALL_SOUND_OFF) || (d1 == CC_ALL_NOTES_OFF));

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            state          <= S_IDLE;
            rs_type        <= '0;
            rs_chan        <= '0;
            d1             <= '0;
            o_note_en      <= 1'b0;
            o_note_num     <= '0;
            o_velocity     <= '0;
            o_note_on_stb  <= 1'b0;
            o_note_off_stb <= 1'b0;
        end else begin
            o_note_on_stb  <= 1'b0;
            o_note_off_stb <= 1'b0;
            // Real-time bytes fall through untouched, even inside SysEx.
            if (i_rx_valid && !is_rt) begin
                unique case (1'b1)
                    is_chst: begin
                        rs_type <= i_rx_data[7:4];
                        rs_chan <= i_rx_data[3:0];
                        state   <= S_D1;
                    end
                    is_sysex: begin
                        rs_type <= '0;
                        rs_chan <= '0;
                        state   <= S_SYSEX;
                    end
                    is_syscom: begin
                        rs_type <= '0;
                        rs_chan <= '0;
                        state   <= S_IDLE;
                    end
                    is_data: begin
                        case (state)
                            S_D1: begin
                                if (msg_len(rs_type) == 2'd2) begin
                                    d1    <= d2;
                                    state <= S_D2;
                                end
                            end
                            S_D2: begin
                                state <= S_D1;
                                if (accept && msg_on) begin
                                    o_note_en     <= 1'b1;
                                    o_note_num    <= d1;
                                    o_velocity    <= d2;
                                    o_note_on_stb <= 1'b1;
                                end else if (accept && o_note_en &&
                                             ((msg_off && d1 == o_note_num) ||
                                              msg_cc_off)) begin
                                    o_note_en      <= 1'b0;
                                    o_note_off_stb <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_midi_note_tracker.sv
// Table-driven scoreboard bench for midi_note_tracker.
module tb_midi_note_tracker;

    typedef struct packed {
        logic       en;
        logic [6:0] num;
        logic [6:0] vel;
        logic       on;
        logic       off;
    } out_t;

    typedef struct {
        logic       v;
        logic [7:0] b;
        out_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       res_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;

    logic       en, on_stb, off_stb;
    logic [6:0] num, vel;
    logic       en_o, on_o, off_o;
    logic [6:0] num_o, vel_o;

    int passed = 0;
    int total  = 0;

    vec_t vecs[$];
    out_t exp_q[$];

    always #5 clk = ~clk;

    midi_note_tracker #(.CHANNEL(4'd0), .OMNI(1'b0)) dut (
        .i_clk(clk), .i_res_n(res_n),
        .i_rx_valid(rx_valid), .i_rx_data(rx_data),
        .o_note_en(en), .o_note_num(num), .o_velocity(vel),
        .o_note_on_stb(on_stb), .o_note_off_stb(off_stb)
    );

    midi_note_tracker #(.CHANNEL(4'd0), .OMNI(1'b1)) dut_omni (
        .i_clk(clk), .i_res_n(res_n),
        .i_rx_valid(rx_valid), .i_rx_data(rx_data),
        .o_note_en(en_o), .o_note_num(num_o), .o_velocity(vel_o),
        .o_note_on_stb(on_o), .o_note_off_stb(off_o)
    );

    function automatic out_t mk(input logic e, input logic [6:0] n,
                                input logic [6:0] ve, input logic o,
                                input logic f);
        out_t r;
        r.en = e; r.num = n; r.vel = ve; r.on = o; r.off = f;
        return r;
    endfunction

    task automatic add(input logic v, input logic [7:0] b, input out_t e);
        vec_t t;
        t.v = v; t.b = b; t.exp = e;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input out_t act);
        out_t e;
        e = exp_q.pop_front();
        total++;
        if (act === e) passed++;
        else $display("FAIL %s: got en=%0b num=%h vel=%h on=%0b off=%0b, want en=%0b num=%h vel=%h on=%0b off=%0b",
                      name, act.en, act.num, act.vel, act.on, act.off,
                      e.en, e.num, e.vel, e.on, e.off);
    endtask

    task automatic send(input logic v, input logic [7:0] b, input out_t e,
                        input string name);
        @(negedge clk);
        rx_valid = v;
        rx_data  = b;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check(name, mk(en, num, vel, on_stb, off_stb));
    endtask

    initial begin
        out_t z;
        z = mk(1'b0, 7'h00, 7'h00, 1'b0, 1'b0);

        // Basic note on
        add(1, 8'h90, z);
        add(1, 8'h3C, z);
        add(1, 8'h64, mk(1, 7'h3C, 7'h64, 1, 0));
        // Running status, last-note priority, vel-0 off
        add(1, 8'h40, mk(1, 7'h3C, 7'h64, 0, 0));
        add(1, 8'h50, mk(1, 7'h40, 7'h50, 1, 0));
        add(1, 8'h40, mk(1, 7'h40, 7'h50, 0, 0));
        add(1, 8'h00, mk(0, 7'h40, 7'h50, 0, 1));
        add(1, 8'h3C, mk(0, 7'h40, 7'h50, 0, 0));
        add(1, 8'h64, mk(1, 7'h3C, 7'h64, 1, 0));
        // Note off for another note: no effect
        add(1, 8'h80, mk(1, 7'h3C, 7'h64, 0, 0));
        add(1, 8'h41, mk(1, 7'h3C, 7'h64, 0, 0));
        add(1, 8'h00, mk(1, 7'h3C, 7'h64, 0, 0));
        add(1, 8'h3C, mk(1, 7'h3C, 7'h64, 0, 0));
        add(1, 8'h00, mk(0, 7'h3C, 7'h64, 0, 1));
        // All-notes-off with nothing sounding
        add(1, 8'hB0, mk(0, 7'h3C, 7'h64, 0, 0));
        add(1, 8'h7B, mk(0, 7'h3C, 7'h64, 0, 0));
        add(1, 8'h00, mk(0, 7'h3C, 7'h64, 0, 0));
        // Real-time interleave, plus idle cycles
        add(1, 8'h90, mk(0, 7'h3C, 7'h64, 0, 0));
        add(1, 8'hF8, mk(0, 7'h3C, 7'h64, 0, 0));
        add(0, 8'h00, mk(0, 7'h3C, 7'h64, 0, 0));
        add(1, 8'h3C, mk(0, 7'h3C, 7'h64, 0, 0));
        add(1, 8'hFE, mk(0, 7'h3C, 7'h64, 0, 0));
        add(1, 8'h64, mk(1, 7'h3C, 7'h64, 1, 0));
        // Note off with nonzero release velocity
        add(1, 8'h80, mk(1, 7'h3C, 7'h64, 0, 0));
        add(1, 8'h3C, mk(1, 7'h3C, 7'h64, 0, 0));
        add(1, 8'h40, mk(0, 7'h3C, 7'h64, 0, 1));
        // All-sound-off with a note sounding
        add(1, 8'h90, mk(0, 7'h3C, 7'h64, 0, 0));
        add(1, 8'h30, mk(0, 7'h3C, 7'h64, 0, 0));
        add(1, 8'h20, mk(1, 7'h30, 7'h20, 1, 0));
        add(1, 8'hB0, mk(1, 7'h30, 7'h20, 0, 0));
        add(1, 8'h78, mk(1, 7'h30, 7'h20, 0, 0));
        add(1, 8'h00, mk(0, 7'h30, 7'h20, 0, 1));
        // SysEx and system common swallow data
        add(1, 8'hF0, mk(0, 7'h30, 7'h20, 0, 0));
        add(1, 8'h3C, mk(0, 7'h30, 7'h20, 0, 0));
        add(1, 8'h64, mk(0, 7'h30, 7'h20, 0, 0));
        add(1, 8'hF7, mk(0, 7'h30, 7'h20, 0, 0));
        add(1, 8'h3C, mk(0, 7'h30, 7'h20, 0, 0));
        add(1, 8'h64, mk(0, 7'h30, 7'h20, 0, 0));
        // Status in D2 discards d1
        add(1, 8'h90, mk(0, 7'h30, 7'h20, 0, 0));
        add(1, 8'h3C, mk(0, 7'h30, 7'h20, 0, 0));
        add(1, 8'h90, mk(0, 7'h30, 7'h20, 0, 0));
        add(1, 8'h40, mk(0, 7'h30, 7'h20, 0, 0));
        add(1, 8'h7F, mk(1, 7'h40, 7'h7F, 1, 0));
        // 1-byte messages consume single data bytes
        add(1, 8'hC0, mk(1, 7'h40, 7'h7F, 0, 0));
        add(1, 8'h3C, mk(1, 7'h40, 7'h7F, 0, 0));
        add(1, 8'h64, mk(1, 7'h40, 7'h7F, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(z);
        check("reset", mk(en, num, vel, on_stb, off_stb));
        @(negedge clk);
        res_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            send(vecs[i].v, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

        // Reset mid-message loses the partial note
        send(1, 8'h90, mk(1, 7'h40, 7'h7F, 0, 0), "rst_pre0");
        send(1, 8'h3C, mk(1, 7'h40, 7'h7F, 0, 0), "rst_pre1");
        @(negedge clk);
        rx_valid = 1'b0;
        res_n = 1'b0;
        #1;
        exp_q.push_back(z);
        check("rst_async", mk(en, num, vel, on_stb, off_stb));
        @(negedge clk);
        res_n = 1'b1;
        send(1, 8'h64, z, "rst_post0");
        send(1, 8'h3C, z, "rst_post1");
        send(1, 8'h64, z, "rst_post2");

        // Channel filter vs omni
        send(1, 8'h91, z, "ch1_s");
        send(1, 8'h3C, z, "ch1_d1");
        send(1, 8'h64, z, "ch1_d2");
        exp_q.push_back(mk(1, 7'h3C, 7'h64, 1, 0));
        check("omni_on", mk(en_o, num_o, vel_o, on_o, off_o));
        @(negedge clk);
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        exp_q.push_back(mk(1, 7'h3C, 7'h64, 0, 0));
        check("omni_hold", mk(en_o, num_o, vel_o, on_o, off_o));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, want finish");
        $fatal(1);
    end

endmodule
